ad9648_spi_master: RTL and testbench

- SPI controller that executes the register transfers requested by the ADC control FSM.
- Accepts a 24-bit instruction+data word and a one-cycle start strobe, then runs one AD9648 3-wire SPI frame on CSB/SCLK/SDIO.
- Returns the 8-bit readback byte with a one-cycle done pulse.
- Sits between the control FSM and the AD9648 pins; the top-level IOBUF uses sdio_t_o.

---
 rtl/ad9648_spi_master.sv | 172 +++++++++++++++++
 tb/tb_ad9648_spi_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9648_spi_master.sv
// ad9648_spi_master: runs one AD9648 SPI frame (instruction+address+data) per start strobe.
// Ports: clk_i/rst_clk_ni (sync, active-low); tx_reg_i + transfer_start_i request a frame;
//   rx_reg_o/transfer_done_o/busy_o report status; csb_o/sclk_o/sdio_o/sdio_t_o/sdio_i drive pins.
// Option SPI_4WIRE_SDO_EN: adds sdo_i as the read-data source and keeps SDIO driven (no turnaround).
// Latency: done pulse 2+(2*TxRegWidth+1)*HALF_DIV+CSB_GAP-1 cycles after the accepted start.
// Backpressure: starts are ignored while busy_o=1; a start in the done cycle is accepted.
module ad9648_spi_master #(
  parameter int TxRegWidth = 24,
  parameter int RxRegWidth = 8,
  parameter int HALF_DIV   = 4,
  parameter int CSB_GAP    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_clk_ni,
  input  logic [TxRegWidth-1:0] tx_reg_i,
  input  logic                  transfer_start_i,
  output logic [RxRegWidth-1:0] rx_reg_o,
  output logic                  transfer_done_o,
  output logic                  busy_o,
  output logic                  csb_o,
  output logic                  sclk_o,
  output logic                  sdio_o,
  input  logic                  sdio_i,
`ifdef SPI_4WIRE_SDO_EN
  input  logic                  sdo_i,
`endif
  output logic                  sdio_t_o
);

  localparam int CntMax = (HALF_DIV > CSB_GAP) ? HALF_DIV : CSB_GAP;
  localparam int CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int BW     = $clog2(TxRegWidth + 1);

  localparam logic [CW-1:0] HalfLast  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GapLast   = CW'(CSB_GAP - 1);
  localparam logic [BW-1:0] BitsTotal = BW'(TxRegWidth);
  // Rising-edge count after which the readback phase begins.
  localparam logic [BW-1:0] RxStart   = BW'(TxRegWidth - RxRegWidth);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]            r_state;
  logic [TxRegWidth-1:0] r_shift;     // MSB is the bit currently on sdio_o
  logic                  r_read;
  logic [RxRegWidth-1:0] r_rx_shift;
  logic [RxRegWidth-1:0] r_rx_reg;
  logic [CW-1:0]         r_cnt;       // half-period / gap cycle counter
  logic [BW-1:0]         r_bcnt;      // rising edges seen this frame
  logic                  r_csb;
  logic                  r_sclk;
  logic                  r_sdio_t;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_sdi;
  logic                  w_half_end;

`ifdef SPI_4WIRE_SDO_EN
  assign w_sdi = sdo_i;
`else
  assign w_sdi = sdio_i;
`endif

  assign w_half_end = (r_cnt == HalfLast);

  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_read     <= 1'b0;
      r_rx_shift <= '0;
      r_rx_reg   <= '0;
      r_cnt      <= '0;
      r_bcnt     <= '0;
      r_csb      <= 1'b1;
      r_sclk     <= 1'b0;
      r_sdio_t   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (transfer_start_i) begin
            r_shift  <= tx_reg_i;
            r_read   <= tx_reg_i[TxRegWidth-1];
            r_csb    <= 1'b0;
            r_sdio_t <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_bcnt   <= '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_half_end) begin
            // First rising edge; never part of the readback phase.
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_bcnt  <= BW'(1);
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          if (w_half_end) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              r_bcnt <= r_bcnt + BW'(1);
              if (r_read && (r_bcnt >= RxStart)) begin
                r_rx_shift <= (r_rx_shift << 1) | RxRegWidth'(w_sdi);
              end
            end else begin
              // Falling edge: present the next bit half a period before the ADC samples it.
              r_shift <= r_shift << 1;
`ifndef SPI_4WIRE_SDO_EN
              if (r_read && (r_bcnt == RxStart)) begin
                r_sdio_t <= 1'b1;
              end
`endif
              if (r_bcnt == BitsTotal) begin
                r_state <= S_HOLD;
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (w_half_end) begin
            r_cnt    <= '0;
            r_csb    <= 1'b1;
            r_sdio_t <= 1'b1;
            r_shift  <= '0;
            r_state  <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GapLast) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (r_read) begin
              r_rx_reg <= r_rx_shift;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_reg_o        = r_rx_reg;
  assign transfer_done_o = r_done;
  assign busy_o          = r_busy;
  assign csb_o           = r_csb;
  assign sclk_o          = r_sclk;
  assign sdio_o          = r_shift[TxRegWidth-1];
  assign sdio_t_o        = r_sdio_t;

endmodule

// File: tb/tb_ad9648_spi_master.sv
// tb_ad9648_spi_master: directed frames against a cycle-arithmetic model of the SPI frame.
// Latency: model predicts every output on every cycle from the frame-relative cycle number.
// Backpressure: bench issues extra starts mid-frame and a start in the done cycle.
`timescale 1ns/1ps
module tb_ad9648_spi_master;
  localparam int TX = 24;
  localparam int RX = 8;
  localparam int H  = 2;
  localparam int G  = 4;
  localparam int D        = 2 + (2*TX+1)*H + G - 1;  // done cycle, 103
  localparam int LAST_LOW = 2*TX*H + H;              // last cycle with csb low, 98
  localparam int TURN     = 1 + 2*H*(TX-RX);         // first cycle with sdio released, 65
`ifdef SPI_4WIRE_SDO_EN
  localparam bit FOUR = 1'b1;
`else
  localparam bit FOUR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [TX-1:0] tx_reg = '0;
  logic          start = 1'b0;
  logic          sdio_i = 1'b0;
`ifdef SPI_4WIRE_SDO_EN
  logic          sdo_i = 1'b0;
`endif
  logic [RX-1:0] rx_reg_o;
  logic          transfer_done_o, busy_o, csb_o, sclk_o, sdio_o, sdio_t_o;

  always #5 clk_i = ~clk_i;

  ad9648_spi_master #(.TxRegWidth(TX), .RxRegWidth(RX), .HALF_DIV(H), .CSB_GAP(G)) dut (
    .clk_i(clk_i), .rst_clk_ni(rst_n), .tx_reg_i(tx_reg), .transfer_start_i(start),
    .rx_reg_o(rx_reg_o), .transfer_done_o(transfer_done_o), .busy_o(busy_o),
    .csb_o(csb_o), .sclk_o(sclk_o), .sdio_o(sdio_o), .sdio_i(sdio_i),
`ifdef SPI_4WIRE_SDO_EN
    .sdo_i(sdo_i),
`endif
    .sdio_t_o(sdio_t_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  int            m_n = 0;       // frame-relative cycle, 0 = idle
  bit            m_valid = 1'b0;
  logic [TX-1:0] m_word = '0;
  logic          m_read = 1'b0;
  logic [RX-1:0] m_rx = '0;
  logic [RX-1:0] m_adc = '0;
  logic [RX-1:0] adc_byte = '0;

  always @(posedge clk_i) begin
    if (!rst_n) begin
      m_n = 0; m_rx = '0; m_valid = 1'b1;
    end else if ((m_n == 0 || m_n == D) && start) begin
      m_n = 1; m_word = tx_reg; m_read = tx_reg[TX-1]; m_adc = adc_byte;
    end else if (m_n == D) begin
      m_n = 0;
    end else if (m_n > 0) begin
      m_n = m_n + 1;
      if (m_n == D && m_read) m_rx = m_adc;
    end
  end

  // {csb, sclk, sdio, sdio_t, busy, done, rx}
  function automatic logic [13:0] exp_out(input int n);
    logic csb, sclk, sdo, t;
    int f;
    if (n == 0) return {6'b100100, m_rx};
    csb  = (n > LAST_LOW);
    sclk = (n >= 1+H) && (n < 1+2*TX*H) && ((((n-1-H)/H) % 2) == 0);
    f    = (n-1) / (2*H);
    sdo  = (!csb && f < TX) ? m_word[TX-1-f] : 1'b0;
    if (csb) t = 1'b1;
    else if (FOUR) t = 1'b0;
    else t = m_read && (n >= TURN);
    return {csb, sclk, sdo, t, (n < D), (n == D), m_rx};
  endfunction

  always @(negedge clk_i) begin
    if (m_valid) begin
      logic [13:0] act, want;
      act  = {csb_o, sclk_o, sdio_o, sdio_t_o, busy_o, transfer_done_o, rx_reg_o};
      want = exp_out(m_n);
      checks++;
      if (act !== want) begin
        failures++;
        $display("FAIL cycle_cmp n=%0d got=%h want=%h", m_n, act, want);
      end
    end
  end

  // ---------------- event recorder + ADC model ----------------
  logic prev_csb = 1'b1, prev_sclk = 1'b0, prev_t = 1'b1;
  int rises = 0, fall_rel = -1, first_rise_rel = -1, last_fall_rel = -1;
  int csb_rise_rel = -1, csb_rise_cyc = -1, gap_len = -1, turn_rel = -1;
  int done_rel = -1, done_cnt = 0, done_run = 0, max_run = 0, csb_falls = 0;
  logic [TX-1:0] cap = '0;
  logic adc_bit;

  always @(negedge clk_i) begin
    if (prev_csb === 1'b1 && csb_o === 1'b0) begin
      csb_falls++; fall_rel = cyc - t0; rises = 0; cap = '0;
      if (csb_rise_cyc >= 0) gap_len = cyc - csb_rise_cyc;
    end
    if (prev_csb === 1'b0 && csb_o === 1'b1) begin
      csb_rise_cyc = cyc; csb_rise_rel = cyc - t0;
    end
    if (prev_sclk === 1'b0 && sclk_o === 1'b1) begin
      rises++; cap = {cap[TX-2:0], sdio_o};
      if (rises == 1) first_rise_rel = cyc - t0;
    end
    if (prev_sclk === 1'b1 && sclk_o === 1'b0) last_fall_rel = cyc - t0;
    if (prev_t === 1'b0 && sdio_t_o === 1'b1 && csb_o === 1'b0) turn_rel = cyc - t0;
    if (transfer_done_o === 1'b1) begin
      done_cnt++; done_run++; done_rel = cyc - t0;
      if (done_run > max_run) max_run = done_run;
    end else begin
      done_run = 0;
    end
    // ADC answers on falling edges once the instruction/address phase is over.
    if (csb_o === 1'b0 && sclk_o === 1'b0 && rises >= TX-RX && rises < TX) begin
      adc_bit = adc_byte[TX-1-rises];
`ifdef SPI_4WIRE_SDO_EN
      sdo_i = adc_bit; sdio_i = ~adc_bit;
`else
      sdio_i = adc_bit;
`endif
    end
    prev_csb = csb_o; prev_sclk = sclk_o; prev_t = sdio_t_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_i); #1;
  endtask

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic start_frame(input logic [TX-1:0] w, input logic [RX-1:0] adc);
    tx_reg = w; adc_byte = adc; start = 1'b1; t0 = cyc;
    @(posedge clk_i); #1 start = 1'b0;
  endtask

  task automatic pulse_at(input int rel);
    for (int k = 0; k < 300 && (cyc - t0) < rel; k++) tick();
    tx_reg = '1; start = 1'b1;
    @(posedge clk_i); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      if (transfer_done_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s no done pulse within 300 cycles", name);
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, cf0;
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_csb", csb_o, 1); chk("rst_sclk", sclk_o, 0); chk("rst_sdio", sdio_o, 0);
    chk("rst_sdio_t", sdio_t_o, 1); chk("rst_busy", busy_o, 0);
    chk("rst_done", transfer_done_o, 0); chk("rst_rx", rx_reg_o, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Write frame 0x000855
    turn_rel = -1;
    start_frame(24'h000855, 8'h00);
    wait_done("wr_done");
    chk("wr_csb_fall", fall_rel, 1);
    chk("wr_first_rise", first_rise_rel, 3);
    chk("wr_rises", rises, 24);
    chk("wr_bits", cap, 24'h000855);
    chk("wr_last_fall", last_fall_rel, 97);
    chk("wr_csb_rise", csb_rise_rel, 99);
    chk("wr_done_cyc", done_rel, 103);
    chk("wr_no_release", turn_rel, -1);
    chk("wr_rx_kept", rx_reg_o, 0);
    repeat (3) tick();

    // Read frame 0x800100, ADC returns 0xA5
    turn_rel = -1; max_run = 0;
    start_frame(24'h800100, 8'hA5);
    wait_done("rd_done");
    chk("rd_rx", rx_reg_o, 8'hA5);
    chk("rd_instr_bits", cap[23:8], 16'h8001);
    chk("rd_turnaround", turn_rel, FOUR ? -1 : TURN);
    tick();
    chk("rd_done_width", max_run, 1);
    repeat (3) tick();

    // Starts during a frame are ignored
    dc0 = done_cnt; cf0 = csb_falls;
    start_frame(24'h0ACE3C, 8'h00);
    pulse_at(10);
    pulse_at(50);
    wait_done("ign_done");
    repeat (10) tick();
    chk("ign_one_done", done_cnt - dc0, 1);
    chk("ign_one_csb", csb_falls - cf0, 1);

    // Back-to-back: second start in the done cycle
    start_frame(24'h800200, 8'h3C);
    wait_done("b2b_first_done");
    chk("b2b_rx1", rx_reg_o, 8'h3C);
    start_frame(24'h000311, 8'h00);
    wait_done("b2b_second_done");
    chk("b2b_csb_gap", gap_len, G + 1);
    chk("b2b_done_cyc", done_rel, 103);
    chk("b2b_rx_kept", rx_reg_o, 8'h3C);
    repeat (3) tick();

    // Reset in the middle of SHIFT
    start_frame(24'h8000FF, 8'h77);
    for (int k = 0; k < 200 && rises != 12; k++) tick();
    chk("mid_reach_bit12", rises, 12);
    rst_n = 1'b0;
    @(posedge clk_i); #1;
    chk("mid_csb", csb_o, 1); chk("mid_sclk", sclk_o, 0);
    chk("mid_sdio_t", sdio_t_o, 1); chk("mid_busy", busy_o, 0); chk("mid_rx", rx_reg_o, 0);
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (150) tick();
    chk("mid_no_done", done_cnt - dc0, 0);
    start_frame(24'h800300, 8'hC3);
    wait_done("mid_recover_done");
    chk("mid_recover_rx", rx_reg_o, 8'hC3);
    chk("mid_recover_cyc", done_rel, 103);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
